pwm_deadtime: RTL
=================

# pwm_deadtime

Dead-time insertion stage sitting directly downstream of the PWM core. Each PWM channel is converted into a complementary high-side/low-side gate-drive pair. A programmable both-off interval is inserted on every transition, and pulses shorter than the dead time are suppressed. Outputs feed the pad muxing (cio) in place of the raw PWM outputs.

## Interface
- NOutputs, 2, number of independent PWM channels
- DtCntDw, 8, width of dead-time counters and dead-time configuration inputs

- clk_i  input  1  core clock; single clock domain
- rst_ni  input  1  asynchronous, active-low reset
- en_i  input  NOutputs  per-channel enable; 0 forces both gate outputs low
- pwm_i  input  NOutputs  raw PWM from the PWM core (same clock domain)
- dt_rise_i  input  DtCntDw  cycles both outputs are low before hs_o rises (shared across channels)
- dt_fall_i  input  DtCntDw  cycles both outputs are low before ls_o rises (shared across channels)
- hs_o  output  NOutputs  high-side drive; follows pwm_i=1, registered
- ls_o  output  NOutputs  low-side drive; follows pwm_i=0, registered
- dt_active_o  output  NOutputs  1 while the channel is in a dead-time interval

## Operation
- Each channel has an independent FSM with states OFF, HS_ON, LS_ON, DT_TO_HS and DT_TO_LS, plus a DtCntDw-bit down-counter.
- Outputs are pure state decodes, registered:
  - hs_o = (state==HS_ON)
  - ls_o = (state==LS_ON)
  - dt_active_o = DT_TO_HS or DT_TO_LS
- Invariant: hs_o & ls_o is never 1 on any channel in any cycle.
- Transitions, evaluated at each clk_i rising edge; en_i=0 has top priority:
  - any state with en_i=0 → OFF.
  - OFF with en_i=1 → HS_ON if pwm_i=1, else LS_ON. There is no dead time, because both outputs were already low.
  - LS_ON with pwm_i=1:
    - if dt_rise_i==0 → HS_ON directly.
    - otherwise → DT_TO_HS, with cnt loaded to dt_rise_i−1.
  - HS_ON with pwm_i=0:
    - if dt_fall_i==0 → LS_ON directly.
    - otherwise → DT_TO_LS, with cnt loaded to dt_fall_i−1.
  - DT_TO_HS:
    - pwm_i=0 → LS_ON (abort: the pulse is suppressed).
    - else if cnt==0 → HS_ON.
    - else cnt−1.
  - DT_TO_LS:
    - pwm_i=1 → HS_ON (abort).
    - else if cnt==0 → LS_ON.
    - else cnt−1.
- Dead-time values are sampled only on DT entry. Changes to dt_*_i during a count do not affect that count.
- Counter arithmetic is unsigned. The maximum dead time is 2^DtCntDw−1 cycles. The counter never wraps, because decrement happens only when cnt≠0.

## Timing
- Reset (rst_ni=0, asynchronous assert):
  - state=OFF, cnt=0.
  - hs_o=0, ls_o=0, dt_active_o=0 immediately, without waiting for a clock.
- Reset deassertion is synchronous to clk_i. The first transition occurs at the first edge after release.
- Latency:
  - pwm_i change to the first output change is 1 cycle (the output updates on the edge that samples pwm_i).
  - With dt=D>0, the both-low interval is exactly D cycles, then the opposite output rises.
- en_i falling: both outputs are 0 one edge later, regardless of any in-progress dead time.
- Simultaneous en_i=0 and a pwm_i edge: en_i wins and the state goes to OFF.
- Reset mid-dead-time: the count is discarded and the channel restarts from OFF.
- Channels are fully independent; there is no cross-channel interaction.

## Configuration
- PWM_DEADTIME_IN_REG_EN
  - Defined: pwm_i and en_i pass through one register stage (reset value 0) before the FSM. Latency from input change to output change becomes 2 cycles. Dead-time lengths are unchanged.
  - Undefined: the FSM samples pwm_i and en_i directly, with 1-cycle latency.
- Test expectations below assume the macro is undefined. Add 1 cycle to every latency when it is defined.

## Test plan
- Reset and enable:
  - Stimulus: rst_ni=0, then release; en_i=2'b01, pwm_i=0.
  - Required: all outputs are 0 during reset. ch0 ls_o=1 one cycle after en_i. ch1 stays hs_o=ls_o=0.
- Nominal dead time:
  - Stimulus: dt_rise_i=3, dt_fall_i=5; ch0 pwm_i rises, held 20 cycles, then falls.
  - Required: ls_o drops after 1 cycle. Both outputs are low for 3 cycles with dt_active_o=1, then hs_o=1. On the fall, both are low for 5 cycles, then ls_o=1.
- Zero dead time:
  - Stimulus: dt_rise_i=0, dt_fall_i=0; toggle pwm_i.
  - Required: hs_o and ls_o swap on the same edge. dt_active_o never asserts, and hs_o&ls_o is never 1.
- Short-pulse suppression:
  - Stimulus: dt_rise_i=4; a pwm_i high pulse of 2 cycles.
  - Required: hs_o never rises. ls_o returns to 1 and dt_active_o is high for 2 cycles.
- Disable mid-dead-time:
  - Stimulus: dt_fall_i=10; en_i drops 3 cycles into DT_TO_LS.
  - Required: on the next edge all outputs are 0. Re-enabling with pwm_i=0 gives ls_o=1 after 1 cycle.
- Config change during count:
  - Stimulus: dt_rise_i=6; change dt_rise_i to 1 two cycles into DT_TO_HS.
  - Required: the both-low interval is still 6 cycles.

Source files
------------

// File: rtl/pwm_deadtime_if.sv
// Gate-drive bundle between the PWM core side and the dead-time stage.
// Contents: per-channel enable and PWM in, shared dead-time config, complementary drives out.
interface pwm_deadtime_if #(
   parameter int NOutputs = 2,
   parameter int DtCntDw  = 8
);
   logic [NOutputs-1:0] en_i;
   logic [NOutputs-1:0] pwm_i;
   logic [DtCntDw-1:0]  dt_rise_i;
   logic [DtCntDw-1:0]  dt_fall_i;
   logic [NOutputs-1:0] hs_o;
   logic [NOutputs-1:0] ls_o;
   logic [NOutputs-1:0] dt_active_o;

   modport master (
      output en_i, pwm_i, dt_rise_i, dt_fall_i,
      input  hs_o, ls_o, dt_active_o
   );

   modport slave (
      input  en_i, pwm_i, dt_rise_i, dt_fall_i,
      output hs_o, ls_o, dt_active_o
   );
endinterface

// File: rtl/pwm_deadtime.sv
// Complementary HS/LS gate drive with programmable dead time and short-pulse suppression.
// Latency 1 cycle (2 with PWM_DEADTIME_IN_REG_EN); no backpressure, inputs sampled every cycle.
module pwm_deadtime #(
   parameter int NOutputs = 2,
   parameter int DtCntDw  = 8
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   pwm_deadtime_if.slave      bus
);
   localparam logic [2:0] OFF      = 3'd0;
   localparam logic [2:0] HS_ON    = 3'd1;
   localparam logic [2:0] LS_ON    = 3'd2;
   localparam logic [2:0] DT_TO_HS = 3'd3;
   localparam logic [2:0] DT_TO_LS = 3'd4;

   localparam logic [DtCntDw-1:0] DT_ZERO = '0;
   localparam logic [DtCntDw-1:0] DT_ONE  = DtCntDw'(1);

   logic [NOutputs-1:0] w_en;
   logic [NOutputs-1:0] w_pwm;

`ifdef PWM_DEADTIME_IN_REG_EN
   logic [NOutputs-1:0] r_en;
   logic [NOutputs-1:0] r_pwm;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_en  <= '0;
         r_pwm <= '0;
      end else begin
         r_en  <= bus.en_i;
         r_pwm <= bus.pwm_i;
      end
   end

   assign w_en  = r_en;
   assign w_pwm = r_pwm;
`else
   assign w_en  = bus.en_i;
   assign w_pwm = bus.pwm_i;
`endif

   for (genvar g = 0; g < NOutputs; g++) begin : g_ch
      logic [2:0]         r_state;
      logic [2:0]         w_nxt_state;
      logic [DtCntDw-1:0] r_cnt;
      logic [DtCntDw-1:0] w_nxt_cnt;
      logic               r_hs;
      logic               r_ls;
      logic               r_dt;

      always_comb begin
         w_nxt_state = r_state;
         w_nxt_cnt   = r_cnt;
         if (!w_en[g]) begin
            w_nxt_state = OFF;
         end else begin
            case (r_state)
               OFF: w_nxt_state = w_pwm[g] ? HS_ON : LS_ON;
               LS_ON: begin
                  if (w_pwm[g]) begin
                     if (bus.dt_rise_i == DT_ZERO) begin
                        w_nxt_state = HS_ON;
                     end else begin
                        w_nxt_state = DT_TO_HS;
                        w_nxt_cnt   = bus.dt_rise_i - DT_ONE;
                     end
                  end
               end
               HS_ON: begin
                  if (!w_pwm[g]) begin
                     if (bus.dt_fall_i == DT_ZERO) begin
                        w_nxt_state = LS_ON;
                     end else begin
                        w_nxt_state = DT_TO_LS;
                        w_nxt_cnt   = bus.dt_fall_i - DT_ONE;
                     end
                  end
               end
               // A PWM reversal inside dead time drops the pending pulse.
               DT_TO_HS: begin
                  if (!w_pwm[g])                w_nxt_state = LS_ON;
                  else if (r_cnt == DT_ZERO)    w_nxt_state = HS_ON;
                  else                          w_nxt_cnt   = r_cnt - DT_ONE;
               end
               DT_TO_LS: begin
                  if (w_pwm[g])                 w_nxt_state = HS_ON;
                  else if (r_cnt == DT_ZERO)    w_nxt_state = LS_ON;
                  else                          w_nxt_cnt   = r_cnt - DT_ONE;
               end
               default: w_nxt_state = OFF;
            endcase
         end
      end

      // Drives are decoded from the next state so the pins come straight off flops.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_state <= OFF;
            r_cnt   <= '0;
            r_hs    <= 1'b0;
            r_ls    <= 1'b0;
            r_dt    <= 1'b0;
         end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_hs    <= (w_nxt_state == HS_ON);
            r_ls    <= (w_nxt_state == LS_ON);
            r_dt    <= (w_nxt_state == DT_TO_HS) || (w_nxt_state == DT_TO_LS);
         end
      end

      assign bus.hs_o[g]        = r_hs;
      assign bus.ls_o[g]        = r_ls;
      assign bus.dt_active_o[g] = r_dt;
   end
endmodule
